// File: rtl/control_unit_seq_pkg.sv
// Decode field types shared by control_unit_seq and anything that consumes its
// outputs (datapath muxes, ALU, register file).
package control_unit_seq_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_HALT  = 6'h3F;

    typedef enum logic [5:0] {
        OP_SLL, OP_SRL, OP_JR, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_J, OP_JAL,
        OP_HALT, OP_ILLEGAL
    } opfunc_t;

    typedef enum logic [1:0] {RD_RT, RD_RD, RD_RA} regdst_t;
    typedef enum logic [1:0] {MTR_ALU, MTR_MEM, MTR_PC} memtoreg_t;
    typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI} extop_t;
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

endpackage

// File: rtl/control_unit_seq.sv
// Sequenced MIPS control unit: holds the fetched instruction, decodes it and
// steps the register-file / data-memory / PC strobes through a small FSM.
//
// state   | meaning
// FETCH   | waiting for ihit, captures instr into instr_q
// EXEC    | single-cycle ops retire here; others branch to MEM/LONG/HALTED
// MEM     | load/store request held until dhit, retire on the dhit cycle
// LONG    | multiply/divide latency countdown, retire when cnt reaches 0
// HALTED  | sticky halt, only RST leaves
module control_unit_seq
    import control_unit_seq_pkg::*;
#(
    parameter int MUL_LAT         = 4,
    parameter int DIV_LAT         = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] instr,
    input  logic        ihit,
    input  logic        dhit,
    output opfunc_t     opfunc,
    output regdst_t     RegDst,
    output memtoreg_t   MemtoReg,
    output logic        ALUSrc,
    output extop_t      ExtOp,
    output aluop_t      ALUOp,
    output logic        RegWEN,
    output logic        dRENi,
    output logic        dWENi,
    output logic        pc_en,
    output logic        busy,
    output logic        halt
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_LONG, S_HALTED} state_t;

    state_t             state_q;
    logic [31:0]        instr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       wr_reg;
    logic       unused_fields;

    assign opcode        = instr_q[31:26];
    assign funct         = instr_q[5:0];
    assign unused_fields = ^instr_q[25:6];

    always_comb begin
        opfunc   = OP_ILLEGAL;
        RegDst   = RD_RT;
        MemtoReg = MTR_ALU;
        ALUSrc   = 1'b0;
        ExtOp    = EXT_ZERO;
        ALUOp    = ALU_ADD;
        wr_reg   = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                RegDst = RD_RD;
                wr_reg = 1'b1;
                case (funct)
                    6'h00: begin opfunc = OP_SLL;  ALUOp = ALU_SLL;  end
                    6'h02: begin opfunc = OP_SRL;  ALUOp = ALU_SRL;  end
                    6'h08: begin opfunc = OP_JR;   wr_reg = 1'b0;    end
                    6'h18: opfunc = OP_MULT;
                    6'h19: opfunc = OP_MULTU;
                    6'h1A: opfunc = OP_DIV;
                    6'h1B: opfunc = OP_DIVU;
                    6'h20: begin opfunc = OP_ADD;  ALUOp = ALU_ADD;  end
                    6'h21: begin opfunc = OP_ADDU; ALUOp = ALU_ADD;  end
                    6'h22: begin opfunc = OP_SUB;  ALUOp = ALU_SUB;  end
                    6'h23: begin opfunc = OP_SUBU; ALUOp = ALU_SUB;  end
                    6'h24: begin opfunc = OP_AND;  ALUOp = ALU_AND;  end
                    6'h25: begin opfunc = OP_OR;   ALUOp = ALU_OR;   end
                    6'h26: begin opfunc = OP_XOR;  ALUOp = ALU_XOR;  end
                    6'h27: begin opfunc = OP_NOR;  ALUOp = ALU_NOR;  end
                    6'h2A: begin opfunc = OP_SLT;  ALUOp = ALU_SLT;  end
                    6'h2B: begin opfunc = OP_SLTU; ALUOp = ALU_SLTU; end
                    default: begin opfunc = OP_ILLEGAL; wr_reg = 1'b0; end
                endcase
            end
            OPC_J:     opfunc = OP_J;
            OPC_JAL:   begin opfunc = OP_JAL; RegDst = RD_RA; MemtoReg = MTR_PC; wr_reg = 1'b1; end
            OPC_BEQ:   begin opfunc = OP_BEQ; ExtOp = EXT_SIGN; ALUOp = ALU_SUB; end
            OPC_BNE:   begin opfunc = OP_BNE; ExtOp = EXT_SIGN; ALUOp = ALU_SUB; end
            OPC_ADDI:  begin opfunc = OP_ADDI;  ALUSrc = 1'b1; ExtOp = EXT_SIGN; ALUOp = ALU_ADD;  wr_reg = 1'b1; end
            OPC_ADDIU: begin opfunc = OP_ADDIU; ALUSrc = 1'b1; ExtOp = EXT_SIGN; ALUOp = ALU_ADD;  wr_reg = 1'b1; end
            OPC_SLTI:  begin opfunc = OP_SLTI;  ALUSrc = 1'b1; ExtOp = EXT_SIGN; ALUOp = ALU_SLT;  wr_reg = 1'b1; end
            OPC_SLTIU: begin opfunc = OP_SLTIU; ALUSrc = 1'b1; ExtOp = EXT_SIGN; ALUOp = ALU_SLTU; wr_reg = 1'b1; end
            OPC_ANDI:  begin opfunc = OP_ANDI;  ALUSrc = 1'b1; ALUOp = ALU_AND; wr_reg = 1'b1; end
            OPC_ORI:   begin opfunc = OP_ORI;   ALUSrc = 1'b1; ALUOp = ALU_OR;  wr_reg = 1'b1; end
            OPC_XORI:  begin opfunc = OP_XORI;  ALUSrc = 1'b1; ALUOp = ALU_XOR; wr_reg = 1'b1; end
            // lui ORs the shifted immediate onto rs, which the encoding fixes at $0
            OPC_LUI:   begin opfunc = OP_LUI; ALUSrc = 1'b1; ExtOp = EXT_LUI; ALUOp = ALU_OR; wr_reg = 1'b1; end
            OPC_LW:    begin opfunc = OP_LW; ALUSrc = 1'b1; ExtOp = EXT_SIGN; MemtoReg = MTR_MEM; wr_reg = 1'b1; end
            OPC_SW:    begin opfunc = OP_SW; ALUSrc = 1'b1; ExtOp = EXT_SIGN; end
            OPC_HALT:  opfunc = OP_HALT;
            default:   opfunc = OP_ILLEGAL;
        endcase
    end

    logic is_mem, is_lw, is_mul, is_div, stop;

    assign is_lw  = (opfunc == OP_LW);
    assign is_mem = is_lw || (opfunc == OP_SW);
    assign is_mul = (opfunc == OP_MULT) || (opfunc == OP_MULTU);
    assign is_div = (opfunc == OP_DIV)  || (opfunc == OP_DIVU);
    assign stop   = (opfunc == OP_HALT) || ((opfunc == OP_ILLEGAL) && HALT_ON_ILLEGAL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ihit) begin
                        instr_q <= instr;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (stop) begin
                        state_q <= S_HALTED;
                    end else if (is_mem) begin
                        state_q <= S_MEM;
                    end else if (is_mul) begin
                        cnt_q   <= MUL_CNT;
                        state_q <= S_LONG;
                    end else if (is_div) begin
                        cnt_q   <= DIV_CNT;
                        state_q <= S_LONG;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dhit) state_q <= S_FETCH;
                end
                S_LONG: begin
                    if (cnt_q == '0) state_q <= S_FETCH;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Moore strobes; only the MEM retire looks at dhit in the same cycle
    always_comb begin
        RegWEN = 1'b0;
        dRENi  = 1'b0;
        dWENi  = 1'b0;
        pc_en  = 1'b0;
        case (state_q)
            S_EXEC: begin
                if (!stop && !is_mem && !is_mul && !is_div) begin
                    pc_en  = 1'b1;
                    RegWEN = wr_reg;
                end
            end
            S_MEM: begin
                dRENi = is_lw;
                dWENi = !is_lw;
                if (dhit) begin
                    pc_en  = 1'b1;
                    RegWEN = is_lw;
                end
            end
            S_LONG: begin
                if (cnt_q == '0) begin
                    pc_en  = 1'b1;
                    RegWEN = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_FETCH);
    assign halt = (state_q == S_HALTED);

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: decode vector table, memory/long-op/halt/reset
// sequences, and a retire scoreboard that checks every pc_en pulse.
module tb_control_unit_seq;
    import control_unit_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] instr;
    logic        ihit, dhit;

    opfunc_t   opfunc, nh_opfunc;
    regdst_t   RegDst, nh_RegDst;
    memtoreg_t MemtoReg, nh_MemtoReg;
    extop_t    ExtOp, nh_ExtOp;
    aluop_t    ALUOp, nh_ALUOp;
    logic ALUSrc, RegWEN, dRENi, dWENi, pc_en, busy, halt;
    logic nh_ALUSrc, nh_RegWEN, nh_dRENi, nh_dWENi, nh_pc_en, nh_busy, nh_halt;

    control_unit_seq #(.MUL_LAT(4), .DIV_LAT(16), .HALT_ON_ILLEGAL(1'b1)) dut (
        .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit),
        .opfunc(opfunc), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
        .ExtOp(ExtOp), .ALUOp(ALUOp), .RegWEN(RegWEN), .dRENi(dRENi), .dWENi(dWENi),
        .pc_en(pc_en), .busy(busy), .halt(halt)
    );

    control_unit_seq #(.MUL_LAT(4), .DIV_LAT(16), .HALT_ON_ILLEGAL(1'b0)) dut_nh (
        .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit),
        .opfunc(nh_opfunc), .RegDst(nh_RegDst), .MemtoReg(nh_MemtoReg), .ALUSrc(nh_ALUSrc),
        .ExtOp(nh_ExtOp), .ALUOp(nh_ALUOp), .RegWEN(nh_RegWEN), .dRENi(nh_dRENi), .dWENi(nh_dWENi),
        .pc_en(nh_pc_en), .busy(nh_busy), .halt(nh_halt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    typedef struct {
        opfunc_t op;
        logic    regwen;
    } retire_t;

    retire_t sb_q[$];

    always @(negedge CLK) begin
        retire_t r;
        if (!RST && pc_en) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected_retire: got pc_en=1 with opfunc %0d, expected no retire", int'(opfunc));
            end else begin
                r = sb_q.pop_front();
                chk("sb_retire_op", int'(opfunc), int'(r.op));
                chk("sb_retire_regwen", int'(RegWEN), int'(r.regwen));
            end
        end
    end

    typedef struct {
        logic [31:0] w;
        opfunc_t     op;
        regdst_t     rd;
        memtoreg_t   m2r;
        logic        alusrc;
        extop_t      ext;
        aluop_t      alu;
        logic        regwen;
    } vec_t;

    vec_t vecs[14];

    task automatic mem_op(input logic [31:0] w, input logic is_lw, input int waits);
        retire_t r;
        r.op = is_lw ? OP_LW : OP_SW;
        r.regwen = is_lw;
        cyc();
        instr = w; ihit = 1'b1;
        sb_q.push_back(r);
        cyc();
        ihit = 1'b0;
        @(negedge CLK);
        chk("mem_exec_noreq", int'(dRENi | dWENi), 0);
        chk("mem_exec_alusrc", int'(ALUSrc), 1);
        for (int i = 0; i <= waits; i++) begin
            cyc();
            dhit = (i == waits);
            @(negedge CLK);
            chk("mem_dreni", int'(dRENi), int'(is_lw));
            chk("mem_dweni", int'(dWENi), int'(!is_lw));
            chk("mem_pc_en", int'(pc_en), int'(i == waits));
            chk("mem_regwen", int'(RegWEN), int'(is_lw && (i == waits)));
            chk("mem_memtoreg", int'(MemtoReg), int'(is_lw ? MTR_MEM : MTR_ALU));
        end
        cyc();
        dhit = 1'b0;
        @(negedge CLK);
        chk("mem_req_dropped", int'(dRENi | dWENi), 0);
        chk("mem_idle", int'(busy), 0);
    endtask

    task automatic long_op(input logic [31:0] w, input opfunc_t op, input int lat);
        retire_t r;
        int nbusy, npe, pe_at;
        r.op = op;
        r.regwen = 1'b1;
        cyc();
        instr = w; ihit = 1'b1;
        sb_q.push_back(r);
        cyc();
        ihit = 1'b0;
        nbusy = 0; npe = 0; pe_at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!busy) break;
            nbusy++;
            if (pc_en) begin npe++; pe_at = nbusy; end
            cyc();
        end
        chk("long_busy_cycles", nbusy, lat + 1);
        chk("long_pc_en_count", npe, 1);
        chk("long_pc_en_cycle", pe_at, lat + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'h00221821, OP_ADDU,  RD_RD, MTR_ALU, 1'b0, EXT_ZERO, ALU_ADD,  1'b1};
        vecs[1]  = '{32'h00221823, OP_SUBU,  RD_RD, MTR_ALU, 1'b0, EXT_ZERO, ALU_SUB,  1'b1};
        vecs[2]  = '{32'h00221824, OP_AND,   RD_RD, MTR_ALU, 1'b0, EXT_ZERO, ALU_AND,  1'b1};
        vecs[3]  = '{32'h00221825, OP_OR,    RD_RD, MTR_ALU, 1'b0, EXT_ZERO, ALU_OR,   1'b1};
        vecs[4]  = '{32'h0022182A, OP_SLT,   RD_RD, MTR_ALU, 1'b0, EXT_ZERO, ALU_SLT,  1'b1};
        vecs[5]  = '{32'h00221827, OP_NOR,   RD_RD, MTR_ALU, 1'b0, EXT_ZERO, ALU_NOR,  1'b1};
        vecs[6]  = '{32'h00000000, OP_SLL,   RD_RD, MTR_ALU, 1'b0, EXT_ZERO, ALU_SLL,  1'b1};
        vecs[7]  = '{32'h24220005, OP_ADDIU, RD_RT, MTR_ALU, 1'b1, EXT_SIGN, ALU_ADD,  1'b1};
        vecs[8]  = '{32'h34220005, OP_ORI,   RD_RT, MTR_ALU, 1'b1, EXT_ZERO, ALU_OR,   1'b1};
        vecs[9]  = '{32'h3C021234, OP_LUI,   RD_RT, MTR_ALU, 1'b1, EXT_LUI,  ALU_OR,   1'b1};
        vecs[10] = '{32'h10220003, OP_BEQ,   RD_RT, MTR_ALU, 1'b0, EXT_SIGN, ALU_SUB,  1'b0};
        vecs[11] = '{32'h08000010, OP_J,     RD_RT, MTR_ALU, 1'b0, EXT_ZERO, ALU_ADD,  1'b0};
        vecs[12] = '{32'h0C000010, OP_JAL,   RD_RA, MTR_PC,  1'b0, EXT_ZERO, ALU_ADD,  1'b1};
        vecs[13] = '{32'h03E00008, OP_JR,    RD_RD, MTR_ALU, 1'b0, EXT_ZERO, ALU_ADD,  1'b0};

        RST = 1'b1; ihit = 1'b1; dhit = 1'b0; instr = 32'h00221821;
        cyc();
        cyc();
        RST = 1'b0; ihit = 1'b0;
        @(negedge CLK);
        chk("rst_busy", int'(busy), 0);
        chk("rst_halt", int'(halt), 0);
        chk("rst_strobes", int'({RegWEN, dRENi, dWENi, pc_en}), 0);
        chk("rst_instr_is_sll", int'(opfunc), int'(OP_SLL));
        cyc();
        @(negedge CLK);
        chk("rst_idle_after", int'(busy), 0);

        foreach (vecs[k]) begin
            retire_t r;
            r.op = vecs[k].op;
            r.regwen = vecs[k].regwen;
            cyc();
            instr = vecs[k].w; ihit = 1'b1;
            sb_q.push_back(r);
            cyc();
            ihit = 1'b0;
            @(negedge CLK);
            chk("vec_opfunc",   int'(opfunc),   int'(vecs[k].op));
            chk("vec_regdst",   int'(RegDst),   int'(vecs[k].rd));
            chk("vec_memtoreg", int'(MemtoReg), int'(vecs[k].m2r));
            chk("vec_alusrc",   int'(ALUSrc),   int'(vecs[k].alusrc));
            chk("vec_extop",    int'(ExtOp),    int'(vecs[k].ext));
            chk("vec_aluop",    int'(ALUOp),    int'(vecs[k].alu));
            chk("vec_regwen",   int'(RegWEN),   int'(vecs[k].regwen));
            chk("vec_pc_en",    int'(pc_en),    1);
            chk("vec_busy_exec", int'(busy),    1);
            cyc();
            @(negedge CLK);
            chk("vec_busy_after", int'(busy), 0);
            chk("vec_pc_en_after", int'(pc_en), 0);
        end

        mem_op(32'h8C220004, 1'b1, 3);
        mem_op(32'hAC220004, 1'b0, 3);
        mem_op(32'h8C220004, 1'b1, 0);

        long_op(32'h00220018, OP_MULT, 4);
        long_op(32'h0022001B, OP_DIVU, 16);

        // reset in the middle of a load wait
        cyc();
        instr = 32'h8C220004; ihit = 1'b1;
        cyc();
        ihit = 1'b0;
        cyc();
        @(negedge CLK);
        chk("rstmem_req_before", int'(dRENi), 1);
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        chk("rstmem_req_dropped", int'(dRENi), 0);
        chk("rstmem_no_retire", int'({pc_en, RegWEN}), 0);
        chk("rstmem_busy", int'(busy), 0);

        cyc();
        instr = 32'hFC000000; ihit = 1'b1;
        cyc();
        ihit = 1'b0;
        @(negedge CLK);
        chk("halt_exec_halt", int'(halt), 0);
        chk("halt_exec_nostrobe", int'({pc_en, RegWEN}), 0);
        cyc();
        @(negedge CLK);
        chk("halt_set", int'(halt), 1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            instr = 32'h00221821; ihit = 1'b1; dhit = 1'b1;
            cyc();
            ihit = 1'b0; dhit = 1'b0;
        end
        @(negedge CLK);
        chk("halt_sticky", int'(halt), 1);
        chk("halt_busy", int'(busy), 1);
        chk("halt_strobes", int'({RegWEN, dRENi, dWENi, pc_en}), 0);
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        chk("halt_cleared", int'(halt), 0);
        chk("halt_cleared_busy", int'(busy), 0);

        cyc();
        instr = 32'h74000000; ihit = 1'b1;
        cyc();
        ihit = 1'b0;
        @(negedge CLK);
        chk("ill_h_pc_en", int'(pc_en), 0);
        chk("ill_nh_pc_en", int'(nh_pc_en), 1);
        chk("ill_nh_regwen", int'(nh_RegWEN), 0);
        chk("ill_nh_opfunc", int'(nh_opfunc), int'(OP_ILLEGAL));
        cyc();
        @(negedge CLK);
        chk("ill_h_halt", int'(halt), 1);
        chk("ill_nh_halt", int'(nh_halt), 0);
        chk("ill_nh_busy", int'(nh_busy), 0);
        cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        @(negedge CLK);
        chk("ill_rst_halt", int'(halt), 0);

        chk("sb_leftover", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
